// File: rtl/frame_timing_rx.sv
// frame_timing_rx: frame/line/data-valid timing receiver and pixel tagger.
// Ports: clk, rst (sync, active-high); fval/lval/dval/pix_in timing inputs;
//   pix_out/pix_valid/pix_x/pix_y pixel stream delayed one cycle;
//   pixels_per_line/lines_per_frame/fval2lval_cycles/lval2dval_cycles
//   measured geometry; frame_done pulse; err_pix/err_lines/err_proto
//   sticky flags. Optional macro FRAME_RX_CHECKSUM_EN adds a 16-bit
//   per-frame pixel checksum output.
module frame_timing_rx #(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480,
    parameter int PIX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fval,
    input  logic             lval,
    input  logic             dval,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_valid,
    output logic [15:0]      pix_x,
    output logic [15:0]      pix_y,
    output logic [15:0]      pixels_per_line,
    output logic [15:0]      lines_per_frame,
    output logic [15:0]      fval2lval_cycles,
    output logic [15:0]      lval2dval_cycles,
    output logic             frame_done,
    output logic             err_pix,
    output logic             err_lines,
    output logic             err_proto
`ifdef FRAME_RX_CHECKSUM_EN
    ,
    output logic [15:0]      checksum
`endif
);

    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FRONT = 3'd2;
    localparam logic [2:0] S_LINE  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]  state;
    logic [15:0] line_pix;
    logic [15:0] line_cnt;
    logic [15:0] col;
    logic [15:0] row;
    logic        l2d_done;

    logic        in_frame;
    logic        frame_start;
    logic        frame_end;
    logic        line_start;
    logic        line_end;
    logic [15:0] row_next;

    always_comb begin
        in_frame    = (state == S_FRONT) || (state == S_LINE) ||
                      (state == S_GAP);
        frame_start = (state == S_IDLE) && fval;
        frame_end   = in_frame && !fval;
        // fval low wins over lval: a frame end is never a line start
        line_start  = ((state == S_FRONT) || (state == S_GAP)) &&
                      fval && lval;
        line_end    = (state == S_LINE) && (!fval || !lval);
        row_next    = (line_cnt == 16'd0) ? 16'd0 : sat_inc(row);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_SYNC;
            line_pix         <= '0;
            line_cnt         <= '0;
            col              <= '0;
            row              <= '0;
            l2d_done         <= 1'b0;
            pix_out          <= '0;
            pix_valid        <= 1'b0;
            pix_x            <= '0;
            pix_y            <= '0;
            pixels_per_line  <= '0;
            lines_per_frame  <= '0;
            fval2lval_cycles <= '0;
            lval2dval_cycles <= '0;
            frame_done       <= 1'b0;
            err_pix          <= 1'b0;
            err_lines        <= 1'b0;
            err_proto        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;

            if (frame_start) begin
                line_pix         <= '0;
                line_cnt         <= '0;
                col              <= '0;
                row              <= '0;
                l2d_done         <= 1'b0;
                lval2dval_cycles <= '0;
                fval2lval_cycles <= lval ? 16'd0 : 16'd1;
                err_pix          <= 1'b0;
                err_lines        <= 1'b0;
                err_proto        <= 1'b0;
            end

            if (state == S_FRONT && fval && !lval)
                fval2lval_cycles <= sat_inc(fval2lval_cycles);

            if (line_start) begin
                line_cnt <= sat_inc(line_cnt);
                row      <= row_next;
                line_pix <= {15'd0, dval};
                if (!l2d_done) begin
                    if (dval) l2d_done <= 1'b1;
                    else      lval2dval_cycles <= 16'd1;
                end
            end

            if (state == S_LINE && fval && lval) begin
                if (dval) line_pix <= sat_inc(line_pix);
                if (!l2d_done) begin
                    if (dval) l2d_done <= 1'b1;
                    else      lval2dval_cycles <= sat_inc(lval2dval_cycles);
                end
            end

            // line close precedes the frame-end line count check
            if (line_end) begin
                pixels_per_line <= line_pix;
                l2d_done        <= 1'b1;
                if (line_pix != 16'(DVAL_HIGH)) err_pix <= 1'b1;
            end

            if (frame_end) begin
                lines_per_frame <= line_cnt;
                frame_done      <= 1'b1;
                if (line_cnt != 16'(ROW_COUNT)) err_lines <= 1'b1;
            end

            // a frame caught mid-flight in SYNC produces nothing
            if (state != S_SYNC) begin
                if ((dval && !lval) || (lval && !fval)) err_proto <= 1'b1;
                if (dval) begin
                    pix_valid <= 1'b1;
                    pix_out   <= pix_in;
                    pix_x     <= (line_start || frame_start) ? 16'd0 : col;
                    pix_y     <= frame_start ? 16'd0 :
                                 line_start  ? row_next : row;
                    col       <= (line_start || frame_start) ? 16'd1 :
                                 sat_inc(col);
                end else if (line_start) begin
                    col <= '0;
                end
            end

            unique case (state)
                S_SYNC:  if (!fval) state <= S_IDLE;
                S_IDLE:  if (fval) state <= S_FRONT;
                S_FRONT: if (!fval) state <= S_IDLE;
                         else if (lval) state <= S_LINE;
                S_LINE:  if (!fval) state <= S_IDLE;
                         else if (!lval) state <= S_GAP;
                S_GAP:   if (!fval) state <= S_IDLE;
                         else if (lval) state <= S_LINE;
                default: state <= S_SYNC;
            endcase
        end
    end

`ifdef FRAME_RX_CHECKSUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_acc  <= '0;
            checksum <= '0;
        end else begin
            if (frame_start) begin
                sum_acc  <= dval ? 16'(pix_in) : 16'd0;
                checksum <= '0;
            end else if (in_frame && fval && dval) begin
                sum_acc <= sum_acc + 16'(pix_in);
            end
            if (frame_end) checksum <= sum_acc;
        end
    end
`endif

endmodule

// File: tb/tb_frame_timing_rx.sv
// tb_frame_timing_rx: scoreboard bench for frame_timing_rx.
// Stimulus queues expected pixels/frame results; a monitor compares them.
module tb_frame_timing_rx;

    localparam int DH = 4;
    localparam int RC = 3;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fval = 1'b0;
    logic          lval = 1'b0;
    logic          dval = 1'b0;
    logic [PW-1:0] pix_in = '0;
    logic [PW-1:0] pix_out;
    logic          pix_valid;
    logic [15:0]   pix_x, pix_y;
    logic [15:0]   pixels_per_line, lines_per_frame;
    logic [15:0]   fval2lval_cycles, lval2dval_cycles;
    logic          frame_done, err_pix, err_lines, err_proto;
`ifdef FRAME_RX_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    frame_timing_rx #(
        .DVAL_HIGH(DH),
        .ROW_COUNT(RC),
        .PIX_W(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fval(fval),
        .lval(lval),
        .dval(dval),
        .pix_in(pix_in),
        .pix_out(pix_out),
        .pix_valid(pix_valid),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pixels_per_line(pixels_per_line),
        .lines_per_frame(lines_per_frame),
        .fval2lval_cycles(fval2lval_cycles),
        .lval2dval_cycles(lval2dval_cycles),
        .frame_done(frame_done),
        .err_pix(err_pix),
        .err_lines(err_lines),
        .err_proto(err_proto)
`ifdef FRAME_RX_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] x;
        logic [15:0] y;
    } pix_t;

    typedef struct {
        logic [15:0] ppl, lpf, f2l, l2d, cs;
        logic        ep, el, epr;
    } frm_t;

    pix_t        pq[$];
    frm_t        fq[$];
    int          checks = 0;
    int          errors = 0;
    int          fd_count = 0;
    int          fd_base;
    logic        fd_prev = 1'b0;
    logic [15:0] cs_acc = '0;
    bit          track = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic l, input logic d,
                       input logic [7:0] p, input int x, input int y);
        pix_t e;
        @(negedge clk);
        fval = f; lval = l; dval = d; pix_in = p;
        if (d && track) begin
            e.d = p; e.x = 16'(x); e.y = 16'(y);
            pq.push_back(e);
            cs_acc += 16'(p);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 8'd0, 0, 0);
    endtask

    task automatic front(input int n);
        cs_acc = '0;
        repeat (n) cyc(1, 0, 0, 8'd0, 0, 0);
    endtask

    task automatic line(input int pre, input int n, input int y,
                        input int base, input int gap);
        repeat (pre) cyc(1, 1, 0, 8'd0, 0, y);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, 8'(base + i), i, y);
        repeat (gap) cyc(1, 0, 0, 8'd0, 0, y);
    endtask

    task automatic expf(input int ppl, input int lpf, input int f2l,
                        input int l2d, input bit ep, input bit el,
                        input bit epr, input int cs);
        frm_t e;
        e.ppl = 16'(ppl); e.lpf = 16'(lpf);
        e.f2l = 16'(f2l); e.l2d = 16'(l2d);
        e.ep = ep; e.el = el; e.epr = epr; e.cs = 16'(cs);
        fq.push_back(e);
    endtask

    always @(negedge clk) begin
        pix_t p;
        frm_t f;
        if (!rst) begin
            if (pix_valid) begin
                if (pq.size() == 0) begin
                    chk("pix_unexpected", 1, 0);
                end else begin
                    p = pq.pop_front();
                    chk("pix_out", pix_out, p.d);
                    chk("pix_x", pix_x, p.x);
                    chk("pix_y", pix_y, p.y);
                end
            end
            if (frame_done) begin
                fd_count++;
                chk("frame_done_width", fd_prev, 0);
                if (fq.size() == 0) begin
                    chk("frame_done_unexpected", 1, 0);
                end else begin
                    f = fq.pop_front();
                    chk("pixels_per_line", pixels_per_line, f.ppl);
                    chk("lines_per_frame", lines_per_frame, f.lpf);
                    chk("fval2lval", fval2lval_cycles, f.f2l);
                    chk("lval2dval", lval2dval_cycles, f.l2d);
                    chk("err_pix", err_pix, f.ep);
                    chk("err_lines", err_lines, f.el);
                    chk("err_proto", err_proto, f.epr);
`ifdef FRAME_RX_CHECKSUM_EN
                    chk("checksum", checksum, f.cs);
`endif
                end
            end
        end
        fd_prev = frame_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ppl", pixels_per_line, 0);
        chk("rst_lpf", lines_per_frame, 0);
        chk("rst_f2l", fval2lval_cycles, 0);
        chk("rst_l2d", lval2dval_cycles, 0);
        chk("rst_errs", {err_pix, err_lines, err_proto}, 0);
        chk("rst_pix", {pix_out, pix_x, pix_y}, 0);
        rst = 1'b0;
        idle(3);

        // clean frame, 5-cycle front, 2-cycle lval-to-dval
        front(5);
        line(2, 4, 0, 1, 2);
        line(2, 4, 1, 5, 2);
        line(2, 4, 2, 9, 2);
        expf(4, 3, 5, 2, 0, 0, 0, 78);
        idle(4);
        chk("fd_count_t1", fd_count, 1);

        // short second line
        front(3);
        line(1, 4, 0, 20, 2);
        line(1, 3, 1, 30, 2);
        chk("ppl_short_line", pixels_per_line, 3);
        chk("err_pix_mid", err_pix, 1);
        line(1, 4, 2, 40, 2);
        expf(4, 3, 3, 1, 1, 0, 0, int'(cs_acc));
        idle(4);

        // clean frame clears err_pix; dval right at lval rise
        front(4);
        chk("err_pix_cleared", err_pix, 0);
        line(0, 4, 0, 60, 2);
        line(0, 4, 1, 64, 2);
        line(0, 4, 2, 68, 2);
        expf(4, 3, 4, 0, 0, 0, 0, int'(cs_acc));
        idle(4);

        // two-line frame
        front(2);
        line(3, 4, 0, 80, 2);
        line(3, 4, 1, 90, 2);
        expf(4, 2, 2, 3, 0, 1, 0, int'(cs_acc));
        idle(4);

        // stray dval in the line gap
        front(2);
        line(1, 4, 0, 50, 1);
        cyc(1, 0, 1, 8'd100, 4, 0);
        cyc(1, 0, 0, 8'd0, 0, 0);
        line(1, 4, 1, 60, 2);
        line(1, 4, 2, 70, 2);
        expf(4, 3, 2, 1, 0, 0, 1, int'(cs_acc));
        idle(4);

        // fval drops while lval high on a 3-pixel last line
        front(2);
        line(1, 4, 0, 10, 2);
        line(1, 4, 1, 14, 2);
        line(1, 3, 2, 18, 0);
        expf(3, 3, 2, 1, 1, 0, 1, int'(cs_acc));
        cyc(0, 1, 0, 8'd0, 0, 0);
        idle(4);
        chk("fd_count_t6", fd_count, 6);

        // reset in mid-frame, then released mid-frame
        fd_base = fd_count;
        front(3);
        line(1, 4, 0, 30, 2);
        rst = 1'b1;
        track = 1'b0;
        cyc(1, 1, 1, 8'd5, 0, 0);
        cyc(1, 1, 1, 8'd6, 0, 0);
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_ppl", pixels_per_line, 0);
        chk("midrst_errs", {err_pix, err_lines, err_proto}, 0);
        rst = 1'b0;
        line(1, 4, 1, 40, 2);
        line(1, 4, 2, 44, 2);
        idle(4);
        chk("no_frame_done_after_rst", fd_count, fd_base);
        track = 1'b1;

        front(5);
        line(2, 4, 0, 1, 2);
        line(2, 4, 1, 5, 2);
        line(2, 4, 2, 9, 2);
        expf(4, 3, 5, 2, 0, 0, 0, 78);
        idle(4);

        chk("fd_count_total", fd_count, 7);
        chk("pix_queue_empty", pq.size(), 0);
        chk("frame_queue_empty", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
